// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter between NUM_SRC array producers. A round-robin
//   arbiter picks a requesting source, its array is copied into a local frame
//   buffer, and the UART is fed one byte at a time:
//   SYNC, HEADER, payload (element DEPTH-1 first, MSB byte first), CHECKSUM.
module uart_tx_scheduler #(
    parameter int         WIDTH     = 32,
    parameter int         DEPTH     = 8,
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [WIDTH-1:0]           src_data [NUM_SRC][DEPTH],
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [7:0]                 byte_out,
    output logic                       frame_busy,
    output logic [$clog2(NUM_SRC)-1:0] active_src
);

    localparam int SW    = $clog2(NUM_SRC);
    localparam int N     = DEPTH * WIDTH / 8;
    localparam int FBITS = DEPTH * WIDTH;
    localparam int CW    = $clog2(N + 4);

    // Byte counter values: 0 = SYNC, 1 = HEADER, 2..N+1 = payload, N+2 = CHECKSUM
    localparam logic [CW-1:0] CNT_SYNC = '0;
    localparam logic [CW-1:0] CNT_HDR  = CW'(1);
    localparam logic [CW-1:0] CNT_CHK  = CW'(N + 2);
    localparam logic [CW-1:0] CNT_END  = CW'(N + 3);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SW-1:0]    r_rr_ptr;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_chk;
    logic [FBITS-1:0] r_frame;
    logic             w_found;
    logic [SW-1:0]    w_win;
    logic             w_accept;
    logic             w_payload;
    logic [7:0]       w_header;
    logic [7:0]       w_frame_top;

    // Source index base+off, wrapping at NUM_SRC
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        return SW'(sum);
    endfunction

    assign w_accept    = (r_state == IDLE) && w_found && !rst;
    assign w_payload   = (r_cnt > CNT_HDR) && (r_cnt < CNT_CHK);
    assign w_header    = {{(8 - SW){1'b0}}, active_src};
    assign w_frame_top = r_frame[FBITS-1 -: 8];

    // Round-robin search from r_rr_ptr upward, wrapping; first requester wins
    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && src_valid[wrap_inc(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_inc(r_rr_ptr, i);
            end
        end
    end

    // Next-state decode and the combinational handshake outputs
    always_comb begin
        w_next    = r_state;
        src_ready = '0;
        tx_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    src_ready[w_win] = 1'b1;
                    w_next           = LOAD;
                end
            end
            LOAD:    w_next = SEND;
            SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    w_next   = WAIT_HI;
                end
            end
            WAIT_HI: if (tx_busy) w_next = WAIT_LO;
            WAIT_LO: if (!tx_busy) w_next = (r_cnt == CNT_END) ? DONE : LOAD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, byte sequencing and checksum; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register sees the values from before the edge.
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_chk      <= '0;
            byte_out   <= '0;
            frame_busy <= 1'b0;
            active_src <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        active_src <= w_win;
                        r_rr_ptr   <= wrap_inc(w_win, 1);
                        frame_busy <= 1'b1;
                        r_cnt      <= '0;
                        r_chk      <= '0;
                    end
                end
                LOAD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_SYNC) begin
                        byte_out <= SYNC_BYTE;
                    end else if (r_cnt == CNT_HDR) begin
                        byte_out <= w_header;
                        r_chk    <= r_chk ^ w_header;
                    end else if (r_cnt == CNT_CHK) begin
                        byte_out <= r_chk;
                    end else begin
                        byte_out <= w_frame_top;
                        r_chk    <= r_chk ^ w_frame_top;
                    end
                end
                DONE:    frame_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // Frame buffer: capture the winner's array on accept, shift out one byte per payload load
    always_ff @(posedge clk) begin
        // NOTE: the frame buffer holds data only and is not reset; it is always written on accept before any byte is read.
        if (w_accept) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_frame[e*WIDTH +: WIDTH] <= src_data[w_win][e];
            end
        end else if (r_state == LOAD && w_payload) begin
            r_frame <= r_frame << 8;
        end
    end

endmodule
